data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder_pkg.sv | 18 +
 rtl/data_mem_responder_if.sv | 25 ++
 rtl/data_mem_responder_ram.sv | 28 ++
 rtl/data_mem_responder.sv | 111 +++++++++++
 tb/tb_data_mem_responder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared constants and types for the CPU data-memory responder:
// register-window offsets, default window base and region decode.
package dmem_pkg;

    localparam logic [1:0] LED_OFF          = 2'd0;
    localparam logic [1:0] CYCLE_OFF        = 2'd1;
    localparam logic [1:0] FAULT_ADDR_OFF   = 2'd2;
    localparam logic [1:0] FAULT_STATUS_OFF = 2'd3;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0000_2000;

    typedef enum logic [1:0] {
        REG_RAM   = 2'd0,
        REG_MMIO  = 2'd1,
        REG_FAULT = 2'd2
    } region_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port: execute-stage request signals and the
// memory-stage read data returned by the responder.
interface data_mem_responder_if;
    logic [31:0] data_mem_addr;
    logic [31:0] data_mem_WrData;
    logic        data_mem_memwrite;
    logic        data_mem_memread;
    logic [31:0] data_mem_out;

    modport master (
        output data_mem_addr,
        output data_mem_WrData,
        output data_mem_memwrite,
        output data_mem_memread,
        input  data_mem_out
    );

    modport slave (
        input  data_mem_addr,
        input  data_mem_WrData,
        input  data_mem_memwrite,
        input  data_mem_memread,
        output data_mem_out
    );
endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port word RAM with synchronous write and a registered,
// write-first read port. No reset so it maps onto block RAM.
module dmem_ram #(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [WORDS];

    // Write at the edge; read register only loads on a read strobe and
    // forwards the write data when both strobes hit the same edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus a 16-byte register window
// (LED, free-running cycle counter, sticky fault capture). Read data
// is registered at the execute-stage edge for use in the memory stage.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    data_mem_responder_if.slave   bus,
    output logic [7:0]            led
);

    localparam int          AW        = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    region_e     region;
    logic [1:0]  off;
    logic        mmio_we;
    logic        fault_acc;
    logic        clear_req;
    logic        flag_d;
    logic [7:0]  led_d;
    logic [31:0] mmio_rdata;

    logic [31:0] cycle_cnt;
    logic [31:0] fault_addr;
    logic        fault_flag;
    logic [7:0]  led_q;

    region_e     region_p1;
    logic [31:0] mmio_q_p1;
    logic [31:0] ram_rdata_p1;

    assign off = bus.data_mem_addr[3:2];
    assign led = led_q;

    // Address decode, register-window write effects and write-first read mux.
    always_comb begin
        region = REG_FAULT;
        if (bus.data_mem_addr < RAM_BYTES) begin
            region = REG_RAM;
        end else if (bus.data_mem_addr[31:4] == MMIO_BASE[31:4]) begin
            region = REG_MMIO;
        end

        mmio_we   = bus.data_mem_memwrite && (region == REG_MMIO);
        fault_acc = (bus.data_mem_memread || bus.data_mem_memwrite) && (region == REG_FAULT);
        clear_req = mmio_we && (off == FAULT_STATUS_OFF) && bus.data_mem_WrData[0];
        // A fault in the same cycle as a clear leaves the flag set.
        flag_d    = fault_acc || (fault_flag && !clear_req);
        led_d     = (mmio_we && (off == LED_OFF)) ? bus.data_mem_WrData[7:0] : led_q;

        mmio_rdata = 32'h0;
        case (off)
            LED_OFF:          mmio_rdata = {24'h0, led_d};
            CYCLE_OFF:        mmio_rdata = cycle_cnt;
            FAULT_ADDR_OFF:   mmio_rdata = fault_addr;
            FAULT_STATUS_OFF: mmio_rdata = {31'h0, flag_d};
            default:          mmio_rdata = 32'h0;
        endcase
    end

    dmem_ram #(
        .WORDS  (RAM_WORDS),
        .ADDR_W (AW)
    ) u_ram (
        .clk   (clk),
        .we    (bus.data_mem_memwrite && (region == REG_RAM)),
        .re    (bus.data_mem_memread && (region == REG_RAM)),
        .addr  (bus.data_mem_addr[AW+1:2]),
        .wdata (bus.data_mem_WrData),
        .rdata (ram_rdata_p1)
    );

    // Register window state: counter, LED, fault flag and first-fault address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt  <= 32'h0;
            led_q      <= 8'h0;
            fault_flag <= 1'b0;
            fault_addr <= 32'h0;
        end else begin
            cycle_cnt  <= cycle_cnt + 32'd1;
            led_q      <= led_d;
            fault_flag <= flag_d;
            if (fault_acc && (!fault_flag || clear_req)) begin
                fault_addr <= bus.data_mem_addr;
            end
        end
    end

    // Execute -> memory stage: latch region and register-window read data on reads.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            region_p1 <= REG_FAULT;
            mmio_q_p1 <= 32'h0;
        end else if (bus.data_mem_memread) begin
            region_p1 <= region;
            mmio_q_p1 <= (region == REG_MMIO) ? mmio_rdata : 32'h0;
        end
    end

    // Memory-stage output select; reset forces the non-RAM path, which reads 0.
    always_comb begin
        bus.data_mem_out = (region_p1 == REG_RAM) ? ram_rdata_p1 : mmio_q_p1;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table for single-edge
// accesses plus hand sequences for reset-during-read and the cycle counter.
module tb_data_mem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] MB = 32'h0000_2000;

    logic clk;
    logic reset_n;
    logic [7:0] led;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .RAM_WORDS (1024),
        .MMIO_BASE (MB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic        re;
        logic [31:0] exp_out;
        logic [7:0]  exp_led;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r,
                       input logic [31:0] eo, input logic [7:0] el, input string nm);
        vec_t v;
        v.addr = a; v.wd = d; v.we = w; v.re = r;
        v.exp_out = eo; v.exp_led = el; v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        bus.data_mem_addr     = a;
        bus.data_mem_WrData   = d;
        bus.data_mem_memwrite = w;
        bus.data_mem_memread  = r;
    endtask

    logic [31:0] c5, c10;

    initial begin
        add(32'h10,      32'hDEAD_BEEF, 1, 0, 32'h0,         8'h00, "wr_ram_no_read");
        add(32'h10,      32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, "rd_after_wr");
        add(32'h10,      32'h0,         0, 0, 32'hDEAD_BEEF, 8'h00, "hold_idle");
        add(32'h20,      32'h1234_5678, 1, 1, 32'h1234_5678, 8'h00, "wr_rd_same_edge");
        add(32'h23,      32'h0,         0, 1, 32'h1234_5678, 8'h00, "alias_0x23");
        add(32'h10,      32'h0,         0, 1, 32'hDEAD_BEEF, 8'h00, "rd_0x10_again");
        add(MB,          32'hFFFF_FFA5, 1, 0, 32'hDEAD_BEEF, 8'hA5, "led_write");
        add(MB,          32'h0,         0, 1, 32'h0000_00A5, 8'hA5, "led_read");
        add(MB + 4,      32'h0,         1, 0, 32'h0000_00A5, 8'hA5, "cycle_write_ignored");
        add(MB,          32'h1234_5633, 1, 1, 32'h0000_0033, 8'h33, "led_wr_rd_same_edge");
        add(32'h4000,    32'h0,         0, 1, 32'h0,         8'h33, "fault_rd_4000");
        add(MB + 8,      32'h0,         0, 1, 32'h4000,      8'h33, "fault_addr_4000");
        add(MB + 12,     32'h0,         0, 1, 32'h1,         8'h33, "flag_set");
        add(32'h5000,    32'h0,         0, 1, 32'h0,         8'h33, "fault_rd_5000");
        add(MB + 8,      32'h0,         0, 1, 32'h4000,      8'h33, "fault_addr_kept");
        add(MB + 12,     32'h1,         1, 1, 32'h0,         8'h33, "clear_wr_rd");
        add(MB + 12,     32'h0,         0, 1, 32'h0,         8'h33, "flag_clear");
        add(32'h6000,    32'h0,         0, 1, 32'h0,         8'h33, "fault_rd_6000");
        add(MB + 12,     32'h0,         0, 1, 32'h1,         8'h33, "flag_reset");
        add(MB + 8,      32'h0,         0, 1, 32'h6000,      8'h33, "fault_addr_6000");
        add(32'h4000,    32'h55,        1, 0, 32'h6000,      8'h33, "fault_wr_no_out");
        add(MB + 8,      32'h0,         0, 1, 32'h6000,      8'h33, "fault_addr_sticky");
        add(MB + 12,     32'h0,         1, 0, 32'h6000,      8'h33, "status_wr0");
        add(MB + 12,     32'h0,         0, 1, 32'h1,         8'h33, "flag_still_set");
        add(MB + 12,     32'h1,         1, 0, 32'h1,         8'h33, "status_clear_only");
        add(32'hFFC,     32'hCAFE_F00D, 1, 0, 32'h1,         8'h33, "wr_last_word");
        add(32'hFFC,     32'h0,         0, 1, 32'hCAFE_F00D, 8'h33, "rd_last_word");
        add(32'h1000,    32'h0,         0, 1, 32'h0,         8'h33, "rd_past_ram");
        add(MB + 8,      32'h0,         0, 1, 32'h1000,      8'h33, "fault_addr_1000");
        add(MB + 16,     32'h0,         0, 1, 32'h0,         8'h33, "rd_past_window");
        add(MB + 8,      32'h0,         0, 1, 32'h1000,      8'h33, "fault_addr_first");

        reset_n = 1'b0;
        drive(32'h0, 32'h0, 0, 0);
        #1;
        check32("reset_out", bus.data_mem_out, 32'h0);
        check32("reset_led", {24'h0, led}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].re);
            @(posedge clk);
            #1;
            check32({vecs[i].name, "_out"}, bus.data_mem_out, vecs[i].exp_out);
            check32({vecs[i].name, "_led"}, {24'h0, led}, {24'h0, vecs[i].exp_led});
            @(negedge clk);
        end

        // Reset lands between a read edge and the next edge.
        drive(32'h10, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        check32("pre_reset_read", bus.data_mem_out, 32'hDEAD_BEEF);
        #2;
        reset_n = 1'b0;
        #1;
        check32("async_reset_out", bus.data_mem_out, 32'h0);
        check32("async_reset_led", {24'h0, led}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        drive(MB + 4, 32'h0, 0, 1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check32("cycle_first_edge", bus.data_mem_out, 32'h0);
        @(negedge clk);
        drive(MB + 4, 32'h0, 0, 0);
        repeat (4) @(negedge clk);
        drive(MB + 4, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        c5 = bus.data_mem_out;
        check32("cycle_edge6", c5, 32'd5);
        @(negedge clk);
        drive(MB + 4, 32'h0, 0, 0);
        repeat (4) @(negedge clk);
        drive(MB + 4, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        c10 = bus.data_mem_out;
        check32("cycle_delta", c10 - c5, 32'd5);
        check32("led_after_reset", {24'h0, led}, 32'h0);
        @(negedge clk);
        drive(MB + 12, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        check32("flag_after_reset", bus.data_mem_out, 32'h0);
        @(negedge clk);
        drive(MB + 8, 32'h0, 0, 1);
        @(posedge clk);
        #1;
        check32("fault_addr_after_reset", bus.data_mem_out, 32'h0);
        @(negedge clk);
        drive(32'h0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
